// File: rtl/wm_cycle_runner.sv
// wm_cycle_runner: timed wash -> rinse -> spin programme sequencer for one washing machine,
// driving actuator enables and reporting phase and minutes left.
module wm_cycle_runner #(
   parameter int TICK_DIV = 4,
   parameter int MAX_LOAD = 20
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       pause,
   input  logic       abort,
   input  logic [4:0] wash_time,
   input  logic [4:0] rinse_time,
   input  logic [4:0] spin_time,
   input  logic [4:0] cloth_load,
   output logic [2:0] state,
   output logic [4:0] remaining,
   output logic       busy,
   output logic       done,
   output logic       err_overload,
   output logic       motor_en,
   output logic       water_valve,
   output logic       drain_pump,
   output logic       spin_hi
);
   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
   typedef enum logic [2:0] {IDLE, WASH, RINSE, SPIN, DONE, FAULT} state_t;
   state_t st, st_n;
   logic [4:0] rem, rem_n, w_q, r_q, s_q, w_n, r_n, s_n;
   logic [PW-1:0] pre, pre_n;
   logic paused_q, run, tick, act;
   assign run  = st inside {WASH, RINSE, SPIN};
   assign tick = run && !paused_q && pre == PRE_MAX;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st       <= IDLE;
         rem      <= '0;
         pre      <= '0;
         paused_q <= 1'b0;
         w_q      <= '0;
         r_q      <= '0;
         s_q      <= '0;
      end else begin
         st       <= st_n;
         rem      <= rem_n;
         pre      <= pre_n;
         paused_q <= pause;
         w_q      <= w_n;
         r_q      <= r_n;
         s_q      <= s_n;
      end
   end
   // zero-time phases are skipped within the same cycle, both at start and on phase end
   always_comb begin
      st_n  = st;
      rem_n = rem;
      pre_n = pre;
      w_n   = w_q;
      r_n   = r_q;
      s_n   = s_q;
      if (abort && st != IDLE) begin
         st_n  = IDLE;
         rem_n = '0;
         pre_n = '0;
      end else if (st == IDLE && start) begin
         w_n   = wash_time;
         r_n   = rinse_time;
         s_n   = spin_time;
         pre_n = '0;
         rem_n = '0;
         if (int'(cloth_load) > MAX_LOAD) st_n = FAULT;
         else if (wash_time != 5'd0) begin
            st_n  = WASH;
            rem_n = wash_time;
         end else if (rinse_time != 5'd0) begin
            st_n  = RINSE;
            rem_n = rinse_time;
         end else if (spin_time != 5'd0) begin
            st_n  = SPIN;
            rem_n = spin_time;
         end else st_n = DONE;
      end else if (st == DONE) st_n = IDLE;
      else if (run && !paused_q) begin
         pre_n = tick ? '0 : pre + 1'b1;
         if (tick && rem > 5'd1) rem_n = rem - 5'd1;
         else if (tick) begin
            if (st == WASH && r_q != 5'd0) begin
               st_n  = RINSE;
               rem_n = r_q;
            end else if (st != SPIN && s_q != 5'd0) begin
               st_n  = SPIN;
               rem_n = s_q;
            end else begin
               st_n  = DONE;
               rem_n = '0;
            end
         end
      end
   end
   assign act          = !paused_q;
   assign state        = st;
   assign remaining    = rem;
   assign busy         = run;
   assign done         = st == DONE;
   assign err_overload = st == FAULT;
   assign motor_en     = act && run;
   assign water_valve  = act && (st == WASH || st == RINSE);
   assign drain_pump   = act && (st == RINSE || st == SPIN);
   assign spin_hi      = act && st == SPIN;
endmodule

// File: tb/tb_wm_cycle_runner.sv
// tb_wm_cycle_runner: directed and randomized checks of wm_cycle_runner against a
// segment-queue model of the wash programme.
module tb_wm_cycle_runner;
   localparam int TD = 4;
   localparam int ML = 20;
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, pause = 1'b0, abort = 1'b0;
   logic [4:0] wash_time = '0, rinse_time = '0, spin_time = '0, cloth_load = '0;
   logic [2:0] state;
   logic [4:0] remaining;
   logic busy, done, err_overload, motor_en, water_valve, drain_pump, spin_hi;
   logic [14:0] dv;
   int checks = 0, passes = 0, fails = 0;
   wm_cycle_runner #(.TICK_DIV(TD), .MAX_LOAD(ML)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .abort(abort),
      .wash_time(wash_time), .rinse_time(rinse_time), .spin_time(spin_time),
      .cloth_load(cloth_load), .state(state), .remaining(remaining), .busy(busy),
      .done(done), .err_overload(err_overload), .motor_en(motor_en),
      .water_valve(water_valve), .drain_pump(drain_pump), .spin_hi(spin_hi)
   );
   assign dv = {state, remaining, busy, done, err_overload, motor_en, water_valve, drain_pump, spin_hi};
   always #5 clk = ~clk;
   // model: the programme is a queue of (phase, minutes) segments; a phase ends after
   // minutes*TD unpaused cycles, and remaining is derived from elapsed cycles
   int m_st = 0, m_time = 0, m_cnt = 0;
   bit m_pq = 1'b0, was_p = 1'b0;
   int qp[$], qt[$];
   task automatic next_phase();
      if (qp.size() == 0) begin
         m_st   = 4;
         m_time = 0;
      end else begin
         m_st   = qp.pop_front();
         m_time = qt.pop_front();
      end
      m_cnt = 0;
   endtask
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_st = 0; m_time = 0; m_cnt = 0; m_pq = 1'b0;
         qp.delete(); qt.delete();
      end else begin
         was_p = m_pq;
         m_pq  = pause;
         if (abort && m_st != 0) begin
            m_st = 0; m_time = 0; m_cnt = 0;
         end else if (m_st == 0 && start) begin
            qp.delete(); qt.delete();
            if (int'(cloth_load) > ML) m_st = 5;
            else begin
               if (wash_time != 0) begin qp.push_back(1); qt.push_back(int'(wash_time)); end
               if (rinse_time != 0) begin qp.push_back(2); qt.push_back(int'(rinse_time)); end
               if (spin_time != 0) begin qp.push_back(3); qt.push_back(int'(spin_time)); end
               next_phase();
            end
         end else if (m_st == 4) m_st = 0;
         else if (m_st >= 1 && m_st <= 3 && !was_p) begin
            m_cnt++;
            if (m_cnt == m_time * TD) next_phase();
         end
      end
   end
   function automatic logic [14:0] exp_vec();
      bit bz = m_st >= 1 && m_st <= 3;
      bit ac = bz && !m_pq;
      return {3'(m_st), bz ? 5'(m_time - m_cnt / TD) : 5'd0, bz, m_st == 4, m_st == 5,
              ac, ac && (m_st == 1 || m_st == 2), ac && (m_st == 2 || m_st == 3), ac && m_st == 3};
   endfunction
   always @(negedge clk) begin
      checks++;
      if (dv !== exp_vec()) begin
         fails++;
         $display("FAIL cycle_cmp t=%0t dut=%h model=%h", $time, dv, exp_vec());
      end else passes++;
   end
   task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
      end else passes++;
   endtask
   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask
   // returns during the first cycle after the start edge
   task automatic prog(input int w, input int r, input int s, input int l);
      wash_time = 5'(w); rinse_time = 5'(r); spin_time = 5'(s); cloth_load = 5'(l);
      start = 1'b1;
      step(1);
      start = 1'b0;
      #1;
   endtask
   initial begin
      step(3);
      #1 lit("reset_vec", dv, 0);
      rst_n = 1'b1;
      step(1);
      prog(2, 1, 3, 10);
      lit("t1_wash_state", state, 1); lit("t1_wash_rem", remaining, 2);
      lit("t1_wash_act", {motor_en, water_valve, drain_pump, spin_hi}, 4'b1100);
      step(7); #1 lit("t1_c8_state", state, 1); lit("t1_c8_rem", remaining, 1);
      step(1); #1 lit("t1_rinse", {state, drain_pump}, {3'd2, 1'b1});
      step(4); #1 lit("t1_spin", {state, remaining, spin_hi}, {3'd3, 5'd3, 1'b1});
      step(12); #1 lit("t1_done", {state, done}, {3'd4, 1'b1});
      step(1); #1 lit("t1_idle", {state, done}, 4'd0);
      step(1);
      prog(0, 0, 2, 5);
      lit("t2_spin", {state, remaining}, {3'd3, 5'd2});
      step(8); #1 lit("t2_done", state, 4);
      step(1);
      prog(0, 0, 0, 0);
      lit("t3_done", state, 4);
      step(1); #1 lit("t3_idle", state, 0);
      prog(1, 1, 1, 31);
      lit("t4_fault", {state, err_overload, motor_en}, {3'd5, 1'b1, 1'b0});
      start = 1'b1; step(1); start = 1'b0;
      #1 lit("t4_start_ign", state, 5);
      abort = 1'b1; step(1); abort = 1'b0;
      #1 lit("t4_abort", {state, err_overload}, 4'd0);
      prog(2, 1, 1, 10);
      step(1);
      pause = 1'b1;
      step(10);
      #1 lit("t5_paused", {state, remaining, busy, motor_en, water_valve}, {3'd1, 5'd2, 1'b1, 2'b00});
      pause = 1'b0;
      step(1); #1 lit("t5_resume", {motor_en, remaining}, {1'b1, 5'd2});
      step(1); #1 lit("t5_pre_tick", remaining, 2);
      step(1); #1 lit("t5_tick", remaining, 1);
      abort = 1'b1; step(1); abort = 1'b0;
      prog(2, 1, 3, 10);
      step(8);
      wash_time = 5'd31; start = 1'b1;
      step(1); start = 1'b0;
      step(15); #1 lit("t6_done_kept", state, 4);
      step(1);
      prog(2, 1, 3, 10);
      step(13); #1 lit("t7_in_spin", state, 3);
      abort = 1'b1; step(1); abort = 1'b0;
      #1 lit("t7_abort", {state, done}, 4'd0);
      step(2); #1 lit("t7_no_done", done, 0);
      prog(2, 1, 3, 10);
      step(13);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 lit("t8_async_rst", dv, 0);
      step(1);
      rst_n = 1'b1;
      prog(1, 0, 0, 3);
      lit("t8_fresh", {state, remaining}, {3'd1, 5'd1});
      step(4); #1 lit("t8_done", state, 4);
      step(1);
      repeat (3000) begin
         start = ($urandom % 6) == 0;
         abort = ($urandom % 80) == 0;
         if ($urandom % 20 == 0) pause = !pause;
         wash_time  = 5'($urandom % 4);
         rinse_time = 5'($urandom % 4);
         spin_time  = 5'($urandom % 4);
         cloth_load = 5'($urandom_range(0, 24));
         step(1);
      end
      start = 1'b0; abort = 1'b0; pause = 1'b0;
      step(2);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/wm_cycle_runner.md
Name: wm_cycle_runner

Overview:
Downstream consumer of the washing-machine settings held by the home controller (the wash_out/rinse_out/spin_out/cloth_out registers of either machine).
- Executes one wash programme as a timed FSM: WASH -> RINSE -> SPIN -> DONE.
- Drives the machine's actuator enables and reports phase and remaining minutes.
- One instance is placed per washing machine.

Parameters:
TICK_DIV, 4, clk cycles per programme minute (prescaler terminal count + 1); must be >= 2
MAX_LOAD, 20, highest accepted cloth_load value; larger values fault at start

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin programme; sampled only in IDLE
pause  input  1  level; holds timer and drops actuators while high
abort  input  1  return to IDLE from any state; also clears FAULT
wash_time  input  5  wash minutes (wash_out_x)
rinse_time  input  5  rinse minutes (rinse_out_x)
spin_time  input  5  spin minutes (spin_out_x)
cloth_load  input  5  load units (cloth_out_x)
state  output  3  IDLE=0, WASH=1, RINSE=2, SPIN=3, DONE=4, FAULT=5
remaining  output  5  minutes left in current phase
busy  output  1  1 in WASH/RINSE/SPIN
done  output  1  1 for exactly the single DONE cycle
err_overload  output  1  1 while in FAULT
motor_en  output  1  drum motor
water_valve  output  1  inlet valve
drain_pump  output  1  drain pump
spin_hi  output  1  high-speed spin

Behaviour:
Reset (rst_n=0, asynchronous):
- state=IDLE; remaining=0; prescaler=0; paused_q=0.
- All outputs 0; snapshot registers 0.

Input priority, evaluated each rising edge: abort > start (IDLE only) > pause > tick.
- abort in WASH/RINSE/SPIN/DONE/FAULT: next state IDLE, remaining=0, prescaler=0.
- abort in IDLE: no effect.

IDLE with start=1:
- Snapshot wash/rinse/spin times into internal registers; later input changes are ignored until the next start.
- If cloth_load > MAX_LOAD: go to FAULT.
- Else go to the first phase with a nonzero snapshot time, loading remaining with that time.
- If all three times are 0: go to DONE.

start outside IDLE is ignored.

Prescaler:
- Counts 0..TICK_DIV-1 only in WASH/RINSE/SPIN while paused_q=0.
- Internal tick is asserted when prescaler == TICK_DIV-1; prescaler wraps to 0.
- Prescaler clears to 0 on every phase entry.

On tick:
- If remaining > 1: decrement remaining.
- If remaining == 1: advance to the next nonzero phase in order WASH -> RINSE -> SPIN, loading remaining. Zero-time phases are skipped in the same cycle. If no later nonzero phase exists, go to DONE with remaining=0.

Pause:
- paused_q <= pause every cycle.
- While paused_q=1: prescaler and remaining frozen; state held; busy stays 1; all actuators 0.
- Release resumes from the frozen prescaler value; no restart of the minute.

DONE: lasts one cycle (done=1), then IDLE.

FAULT:
- err_overload=1; held until abort; start ignored.

Actuators are a combinational decode of the registered state, gated by ~paused_q:
- WASH: motor_en, water_valve
- RINSE: motor_en, water_valve, drain_pump
- SPIN: motor_en, drain_pump, spin_hi
- other states: all 0

Status decode:
- busy = state in {WASH, RINSE, SPIN}.
- done = (state == DONE).

Timing:
- Phase duration = time × TICK_DIV cycles exactly.
- Latency start -> first phase: 1 cycle.

Reset mid-programme: immediate IDLE; no completion pulse.

Test Plan:
- TICK_DIV=4, wash=2, rinse=1, spin=3, load=10, start pulse at cycle 0 -> required sequence:
  - WASH cycles 1-8 (remaining 2 then 1), motor_en=water_valve=1.
  - RINSE cycles 9-12.
  - SPIN cycles 13-24 with spin_hi=1.
  - DONE at cycle 25 with done=1 for one cycle; IDLE at cycle 26.
- wash=0, rinse=0, spin=2, load=5 -> start goes directly to SPIN, remaining=2; DONE after 8 cycles. All zero times -> DONE one cycle after start.
- load=31 (> MAX_LOAD) + start -> FAULT, err_overload=1, actuators 0; subsequent start ignored; abort -> IDLE next cycle, err_overload=0.
- Pause in WASH, remaining=2, prescaler=2, pause held 10 cycles:
  - actuators 0 and remaining stays 2 for the whole pause, busy=1;
  - after release, tick occurs 2 cycles later.
- Mid-RINSE: change wash_time input and assert start -> no effect on sequence. abort during SPIN -> IDLE next cycle, no done pulse.
- rst_n pulled low asynchronously mid-SPIN (between clock edges) -> all outputs 0 immediately. After release, start runs a fresh programme.
